// File: rtl/ctrl_pkt_gen_if.sv
// rtl/ctrl_pkt_gen_if.sv - request, payload and control-stream bundle for ctrl_pkt_gen
// Ports (signals):
//   req_valid/req_ready, req_stage_id, req_module_id, req_resource_id, req_index, req_len
//   pl_tdata/pl_tvalid/pl_tlast/pl_tready        caller payload stream
//   c_m_axis_tdata/tuser/tkeep/tvalid/tlast      control packet stream (no tready)
//   err_len                                      length mismatch pulse
// master: generator side. slave: caller / downstream side.
interface ctrl_pkt_gen_if #(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128
);
  logic                                req_valid;
  logic                                req_ready;
  logic [4:0]                          req_stage_id;
  logic [2:0]                          req_module_id;
  logic [7:0]                          req_resource_id;
  logic [15:0]                         req_index;
  logic [3:0]                          req_len;

  logic [C_S_AXIS_DATA_WIDTH-1:0]      pl_tdata;
  logic                                pl_tvalid;
  logic                                pl_tlast;
  logic                                pl_tready;

  logic [C_S_AXIS_DATA_WIDTH-1:0]      c_m_axis_tdata;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]     c_m_axis_tuser;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    c_m_axis_tkeep;
  logic                                c_m_axis_tvalid;
  logic                                c_m_axis_tlast;
  logic                                err_len;

  modport master (
    input  req_valid, req_stage_id, req_module_id, req_resource_id, req_index, req_len,
    input  pl_tdata, pl_tvalid, pl_tlast,
    output req_ready, pl_tready,
    output c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tvalid, c_m_axis_tlast,
    output err_len
  );

  modport slave (
    output req_valid, req_stage_id, req_module_id, req_resource_id, req_index, req_len,
    output pl_tdata, pl_tvalid, pl_tlast,
    input  req_ready, pl_tready,
    input  c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tvalid, c_m_axis_tlast,
    input  err_len
  );
endinterface

// File: rtl/ctrl_pkt_gen.sv
// rtl/ctrl_pkt_gen.sv - builds header + payload control packets from table write requests
// Ports:
//   axis_clk    single clock
//   axis_reset  synchronous active-high reset
//   bus         ctrl_pkt_gen_if.master: request, payload stream, control stream, err_len
//   stat_pkts   (CTRL_PKT_GEN_STATS_EN only) saturating count of emitted tlast beats
//   stat_errs   (CTRL_PKT_GEN_STATS_EN only) saturating count of err_len pulses
// Optional feature macro: CTRL_PKT_GEN_STATS_EN
module ctrl_pkt_gen #(
  parameter int          C_S_AXIS_DATA_WIDTH  = 512,
  parameter int          C_S_AXIS_TUSER_WIDTH = 128,
  parameter logic [15:0] CTRL_MAGIC           = 16'hF1F2,
  parameter int          MAX_PL_BEATS         = 8
) (
  input  logic                 axis_clk,
  input  logic                 axis_reset,
  ctrl_pkt_gen_if.master       bus
`ifdef CTRL_PKT_GEN_STATS_EN
  ,
  output logic [31:0]          stat_pkts,
  output logic [15:0]          stat_errs
`endif
);
  localparam int          DW         = C_S_AXIS_DATA_WIDTH;
  localparam int          TW         = C_S_AXIS_TUSER_WIDTH;
  localparam logic [15:0] BEAT_BYTES = 16'(DW / 8);
  localparam logic [3:0]  MAX_LEN    = 4'(MAX_PL_BEATS);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_PAD, S_DRAIN} state_t;

  state_t          state, state_n;
  logic [3:0]      len_q, len_n;
  logic [3:0]      cnt_q, cnt_n;
  logic [3:0]      cnt_inc;
  logic [3:0]      req_len_c;
  logic            req_ready_c;
  logic            pl_tready_c;
  logic [DW-1:0]   tdata_n;
  logic [TW-1:0]   tuser_n;
  logic            tvalid_n;
  logic            tlast_n;
  logic            err_n;

  // While a tlast beat is on the wire the block is back in IDLE but holds off
  // one cycle, guaranteeing an idle cycle between consecutive packets.
  assign req_ready_c   = (state == S_IDLE) && !(bus.c_m_axis_tvalid && bus.c_m_axis_tlast);
  assign pl_tready_c   = (state == S_PAYLOAD) || (state == S_DRAIN);
  assign bus.req_ready = req_ready_c;
  assign bus.pl_tready = pl_tready_c;

  assign req_len_c = (bus.req_len > MAX_LEN) ? MAX_LEN : bus.req_len;
  assign cnt_inc   = cnt_q + 4'd1;

  always_comb begin
    state_n  = state;
    len_n    = len_q;
    cnt_n    = cnt_q;
    tdata_n  = '0;
    tuser_n  = '0;
    tvalid_n = 1'b0;
    tlast_n  = 1'b0;
    err_n    = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.req_valid && req_ready_c) begin
          len_n           = req_len_c;
          cnt_n           = 4'd0;
          tvalid_n        = 1'b1;
          tdata_n[15:0]   = CTRL_MAGIC;
          tdata_n[20:16]  = bus.req_stage_id;
          tdata_n[23:21]  = bus.req_module_id;
          tdata_n[31:24]  = bus.req_resource_id;
          tdata_n[47:32]  = bus.req_index;
          tdata_n[51:48]  = req_len_c;
          tuser_n[15:0]   = ({12'd0, req_len_c} + 16'd1) * BEAT_BYTES;
          tlast_n         = (req_len_c == 4'd0);
          state_n         = (req_len_c == 4'd0) ? S_IDLE : S_PAYLOAD;
        end
      end

      S_PAYLOAD: begin
        if (bus.pl_tvalid) begin
          tvalid_n = 1'b1;
          tdata_n  = bus.pl_tdata;
          cnt_n    = cnt_inc;
          if (cnt_inc == len_q) begin
            tlast_n = 1'b1;
            if (bus.pl_tlast) begin
              state_n = S_IDLE;
            end else begin
              // Caller overran the requested length: swallow the rest.
              err_n   = 1'b1;
              state_n = S_DRAIN;
            end
          end else if (bus.pl_tlast) begin
            // Caller ended early: fill remaining beats with zeros.
            err_n   = 1'b1;
            state_n = S_PAD;
          end
        end
      end

      S_PAD: begin
        tvalid_n = 1'b1;
        cnt_n    = cnt_inc;
        if (cnt_inc == len_q) begin
          tlast_n = 1'b1;
          state_n = S_IDLE;
        end
      end

      S_DRAIN: begin
        if (bus.pl_tvalid && bus.pl_tlast) begin
          state_n = S_IDLE;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (axis_reset) begin
      state               <= S_IDLE;
      len_q               <= 4'd0;
      cnt_q               <= 4'd0;
      bus.c_m_axis_tdata  <= '0;
      bus.c_m_axis_tuser  <= '0;
      bus.c_m_axis_tkeep  <= '0;
      bus.c_m_axis_tvalid <= 1'b0;
      bus.c_m_axis_tlast  <= 1'b0;
      bus.err_len         <= 1'b0;
    end else begin
      state               <= state_n;
      len_q               <= len_n;
      cnt_q               <= cnt_n;
      bus.c_m_axis_tdata  <= tdata_n;
      bus.c_m_axis_tuser  <= tuser_n;
      bus.c_m_axis_tkeep  <= tvalid_n ? '1 : '0;
      bus.c_m_axis_tvalid <= tvalid_n;
      bus.c_m_axis_tlast  <= tlast_n;
      bus.err_len         <= err_n;
    end
  end

`ifdef CTRL_PKT_GEN_STATS_EN
  always_ff @(posedge axis_clk) begin
    if (axis_reset) begin
      stat_pkts <= '0;
      stat_errs <= '0;
    end else begin
      if (bus.c_m_axis_tvalid && bus.c_m_axis_tlast && (stat_pkts != '1)) begin
        stat_pkts <= stat_pkts + 32'd1;
      end
      if (bus.err_len && (stat_errs != '1)) begin
        stat_errs <= stat_errs + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_pkt_gen.sv
// tb/tb_ctrl_pkt_gen.sv - scoreboard bench for ctrl_pkt_gen with randomized requests
`timescale 1ns/1ps
module tb_ctrl_pkt_gen;
  localparam int          DW    = 512;
  localparam int          TW    = 128;
  localparam int          MAXB  = 8;
  localparam logic [15:0] MAGIC = 16'hF1F2;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [TW-1:0] u;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ctrl_pkt_gen_if #(.C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(TW)) bus ();

`ifdef CTRL_PKT_GEN_STATS_EN
  logic [31:0] stat_pkts;
  logic [15:0] stat_errs;
`endif

  ctrl_pkt_gen #(
    .C_S_AXIS_DATA_WIDTH (DW),
    .C_S_AXIS_TUSER_WIDTH(TW),
    .CTRL_MAGIC          (MAGIC),
    .MAX_PL_BEATS        (MAXB)
  ) dut (
    .axis_clk  (clk),
    .axis_reset(rst),
    .bus       (bus)
`ifdef CTRL_PKT_GEN_STATS_EN
    ,
    .stat_pkts (stat_pkts),
    .stat_errs (stat_errs)
`endif
  );

  beat_t exp_q[$];
  int    tests    = 0;
  int    fails    = 0;
  int    err_seen = 0;
  int    rdy_seen = 0;
  int    pkts_exp = 0;
  int    errs_exp = 0;
  int    beat_no  = 0;
  logic  prev_last = 1'b0;

  // Monitor: every presented beat is popped from the scoreboard and compared.
  always @(negedge clk) begin
    beat_t e;
    if (prev_last) begin
      tests++;
      if (bus.c_m_axis_tvalid !== 1'b0) begin
        fails++;
        $display("FAIL pkt_gap: tvalid=%b in cycle after tlast, required 0", bus.c_m_axis_tvalid);
      end
    end
    if (bus.err_len === 1'b1) err_seen++;
    if (bus.pl_tready === 1'b1) rdy_seen++;
    if (bus.c_m_axis_tvalid === 1'b1) begin
      tests++;
      beat_no++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_beat%0d: got data[63:0]=%h last=%b, required no beat",
                 beat_no, bus.c_m_axis_tdata[63:0], bus.c_m_axis_tlast);
      end else begin
        e = exp_q.pop_front();
        if (bus.c_m_axis_tdata !== e.d || bus.c_m_axis_tuser !== e.u ||
            bus.c_m_axis_tlast !== e.l || bus.c_m_axis_tkeep !== '1) begin
          fails++;
          $display("FAIL beat%0d: got data[63:0]=%h data_eq=%b user[15:0]=%h last=%b keep_ones=%b, required data[63:0]=%h user[15:0]=%h last=%b keep_ones=1",
                   beat_no, bus.c_m_axis_tdata[63:0], bus.c_m_axis_tdata === e.d,
                   bus.c_m_axis_tuser[15:0], bus.c_m_axis_tlast, bus.c_m_axis_tkeep === '1,
                   e.d[63:0], e.u[15:0], e.l);
        end
      end
    end
    prev_last = rst ? 1'b0 : (bus.c_m_axis_tvalid === 1'b1 && bus.c_m_axis_tlast === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Header layout straight from the field table: magic, stage, module, resource, index, length.
  function automatic beat_t hdr_beat(input int st, input int md, input int rs, input int ix, input int lc);
    beat_t b;
    b.d = DW'(MAGIC) | (DW'(st) << 16) | (DW'(md) << 21) | (DW'(rs) << 24) |
          (DW'(ix) << 32) | (DW'(lc) << 48);
    b.u = TW'((1 + lc) * (DW / 8));
    b.l = (lc == 0);
    return b;
  endfunction

  task automatic issue_req(input int st, input int md, input int rs, input int ix, input int ln);
    int cyc;
    bus.req_valid       = 1'b1;
    bus.req_stage_id    = 5'(st);
    bus.req_module_id   = 3'(md);
    bus.req_resource_id = 8'(rs);
    bus.req_index       = 16'(ix);
    bus.req_len         = 4'(ln);
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) break;
      cyc++;
    end
    check("req_accept_timeout", 64'(cyc < 100), 64'd1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic last, input int gap);
    int   cyc;
    logic rdy;
    bus.pl_tvalid = 1'b0;
    bus.pl_tlast  = 1'b0;
    repeat (gap) tick();
    bus.pl_tvalid = 1'b1;
    bus.pl_tdata  = d;
    bus.pl_tlast  = last;
    cyc = 0;
    rdy = 1'b0;
    while (!rdy && cyc < 100) begin
      @(negedge clk);
      rdy = (bus.pl_tready === 1'b1);
      tick();
      cyc++;
    end
    check("payload_accept_timeout", 64'(rdy), 64'd1);
    bus.pl_tvalid = 1'b0;
    bus.pl_tlast  = 1'b0;
  endtask

  // gap < 0: random 0..2 idle cycles before each beat; otherwise fixed gap between beats.
  task automatic run_pkt(input int st, input int md, input int rs, input int ix, input int ln,
                         input int n, input int gap);
    logic [DW-1:0] pl[$];
    beat_t b;
    int    lc, e0, cyc, exp_err;
    lc = (ln > MAXB) ? MAXB : ln;
    for (int i = 0; i < n; i++) pl.push_back(rand_beat());
    exp_q.push_back(hdr_beat(st, md, rs, ix, lc));
    for (int i = 0; i < lc; i++) begin
      b.d = (i < n) ? pl[i] : '0;
      b.u = '0;
      b.l = (i == lc - 1);
      exp_q.push_back(b);
    end
    exp_err = (lc > 0 && n != lc) ? 1 : 0;
    pkts_exp++;
    errs_exp += exp_err;
    e0 = err_seen;
    issue_req(st, md, rs, ix, ln);
    for (int i = 0; i < n; i++) begin
      send_beat(pl[i], i == n - 1, (gap < 0) ? int'($urandom_range(0, 2)) : ((i == 0) ? 0 : gap));
    end
    cyc = 0;
    while ((exp_q.size() != 0 || bus.req_ready !== 1'b1) && cyc < 200) begin
      tick();
      cyc++;
    end
    check("pkt_done_timeout", 64'(cyc < 200), 64'd1);
    check("err_len_pulses", 64'(err_seen - e0), 64'(exp_err));
  endtask

  initial begin
    int r0;
    beat_t b;
    bus.req_valid       = 1'b0;
    bus.req_stage_id    = '0;
    bus.req_module_id   = '0;
    bus.req_resource_id = '0;
    bus.req_index       = '0;
    bus.req_len         = '0;
    bus.pl_tdata        = '0;
    bus.pl_tvalid       = 1'b0;
    bus.pl_tlast        = 1'b0;

    repeat (3) tick();
    check("rst_tvalid", 64'(bus.c_m_axis_tvalid), 64'd0);
    check("rst_tlast",  64'(bus.c_m_axis_tlast), 64'd0);
    check("rst_tdata",  64'(bus.c_m_axis_tdata != '0), 64'd0);
    check("rst_tuser",  64'(bus.c_m_axis_tuser != '0), 64'd0);
    check("rst_tkeep",  64'(bus.c_m_axis_tkeep != '0), 64'd0);
    check("rst_err_len", 64'(bus.err_len), 64'd0);
    rst = 1'b0;
    tick();
    check("idle_req_ready", 64'(bus.req_ready), 64'd1);
    check("idle_pl_tready", 64'(bus.pl_tready), 64'd0);

    // Exact-length packet.
    run_pkt(2, 1, 3, 16'h0010, 2, 2, 0);

    // Header-only packet; a payload beat is held valid throughout and must not be taken.
    r0 = rdy_seen;
    bus.pl_tvalid = 1'b1;
    bus.pl_tdata  = rand_beat();
    run_pkt(7, 2, 9, 16'h1234, 0, 0, 0);
    bus.pl_tvalid = 1'b0;
    check("len0_pl_tready_cycles", 64'(rdy_seen - r0), 64'd0);

    // Short payload padded; long payload drained.
    run_pkt(1, 0, 5, 16'hABCD, 3, 1, 0);
    run_pkt(31, 2, 255, 16'hFFFF, 1, 3, 0);

    // Input bubbles: valid pattern 1,0,0,1.
    run_pkt(4, 1, 6, 16'h0042, 2, 2, 2);

    // Clamped length.
    run_pkt(3, 0, 1, 16'h0001, 15, MAXB, 0);

    // Reset in the middle of a payload.
    exp_q.push_back(hdr_beat(5, 1, 2, 16'h0099, 2));
    b.d = rand_beat();
    b.u = '0;
    b.l = 1'b0;
    exp_q.push_back(b);
    issue_req(5, 1, 2, 16'h0099, 2);
    send_beat(b.d, 1'b0, 0);
    rst = 1'b1;
    tick();
    check("reset_mid_tvalid", 64'(bus.c_m_axis_tvalid), 64'd0);
    check("reset_mid_queue", 64'(exp_q.size()), 64'd0);
    rst = 1'b0;
    pkts_exp = 0;
    errs_exp = 0;
    tick();
    run_pkt(6, 2, 8, 16'h0100, 1, 1, 0);

    // Randomized traffic, including lengths above the clamp and mismatched payloads.
    for (int k = 0; k < 40; k++) begin
      int ln, lc, n;
      ln = $urandom_range(0, 15);
      lc = (ln > MAXB) ? MAXB : ln;
      n  = (lc == 0) ? 0 : int'($urandom_range(1, lc + 2));
      run_pkt($urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 255),
              $urandom_range(0, 65535), ln, n, -1);
    end

    repeat (3) tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
`ifdef CTRL_PKT_GEN_STATS_EN
    check("stat_pkts", 64'(stat_pkts), 64'(pkts_exp));
    check("stat_errs", 64'(stat_errs), 64'(errs_exp));
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ctrl_pkt_gen.md
Name: ctrl_pkt_gen

Overview:
- Transmitter end of the stage control path.
- Turns table/register write requests into AXI-Stream control packets on c_m_axis_*. These packets are consumed by the key extractor, lookup engine and action engine chain in each stage.
- Emits one header beat, then the caller's payload beats. Enforces the requested length by padding short payloads or truncating and draining long ones.
- Output has no tready: the downstream control path never back-pressures.

Parameters:
- C_S_AXIS_DATA_WIDTH, 512, control-stream data width in bits; payload beat width.
- C_S_AXIS_TUSER_WIDTH, 128, control-stream tuser width.
- CTRL_MAGIC, 16'hF1F2, control-packet identifier placed in header.
- MAX_PL_BEATS, 8, maximum payload beats per packet (1..15).

Ports:
- axis_clk  in  1  single clock.
- axis_reset  in  1  synchronous, active-high reset.
- req_valid  in  1  write request valid.
- req_ready  out  1  high only in IDLE.
- req_stage_id  in  5  target stage.
- req_module_id  in  3  0=key extractor, 1=lookup, 2=action, others reserved.
- req_resource_id  in  8  table/RAM select within module.
- req_index  in  16  entry index.
- req_len  in  4  payload beats; 0 = header-only packet.
- pl_tdata  in  C_S_AXIS_DATA_WIDTH  payload beat.
- pl_tvalid  in  1  payload valid.
- pl_tlast  in  1  last payload beat from caller.
- pl_tready  out  1  payload accept.
- c_m_axis_tdata  out  C_S_AXIS_DATA_WIDTH
- c_m_axis_tuser  out  C_S_AXIS_TUSER_WIDTH
- c_m_axis_tkeep  out  C_S_AXIS_DATA_WIDTH/8
- c_m_axis_tvalid  out  1
- c_m_axis_tlast  out  1
- err_len  out  1  one-cycle pulse on length mismatch.

Behaviour:
- Reset: state IDLE. c_m_axis_tvalid, tlast, tdata, tuser, tkeep = 0. err_len = 0. Beat counter = 0.
- Reset mid-packet aborts at once; no tlast is emitted; the next packet starts clean.
- All c_m_axis_* and err_len are registered. tvalid may drop between beats of a packet.
- req_len above MAX_PL_BEATS is clamped to MAX_PL_BEATS.
- IDLE:
  - req_ready = 1.
  - On req_valid at cycle T: latch fields. Drive header beat at T+1.
  - Header beat: tdata[15:0] = CTRL_MAGIC; [20:16] = stage_id; [23:21] = module_id; [31:24] = resource_id; [47:32] = index; [51:48] = req_len; rest 0.
  - Header tuser[15:0] = (1 + len) × (C_S_AXIS_DATA_WIDTH/8) bytes; rest 0. tkeep all ones on every beat.
  - len = 0: header carries tlast = 1; return to IDLE. Otherwise go to PAYLOAD with cnt = 0.
- PAYLOAD:
  - pl_tready = 1.
  - Beat accepted at t appears at t+1 with tkeep all ones; cnt increments.
  - Beat where cnt+1 == len: output tlast = 1.
    - If pl_tlast = 1, go to IDLE.
    - Else pulse err_len and go to DRAIN.
  - pl_tlast with cnt+1 < len: pulse err_len and go to PAD.
- PAD:
  - pl_tready = 0.
  - Emit zero beats on consecutive cycles until len beats are sent; last one carries tlast. Then IDLE.
- DRAIN:
  - pl_tready = 1. Accept and discard beats; nothing is emitted.
  - On accepted pl_tlast, go to IDLE.
- req_ready = 0 outside IDLE.
- A request offered in the same cycle as a packet's final beat is accepted on the next IDLE cycle. Minimum packet-to-packet gap is one idle cycle on c_m_axis.
- pl_tready = 0 in IDLE. Payload presented with no request is never consumed.
- pl_tvalid low in PAYLOAD inserts output bubbles (tvalid = 0); there is no timeout.

Optional Feature:
- Macro: CTRL_PKT_GEN_STATS_EN.
- Defined: adds outputs stat_pkts[31:0] (increments on every emitted tlast) and stat_errs[15:0] (increments on every err_len pulse). Both counters saturate at all-ones and reset to 0.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset, then req stage 2, module 1, resource 3, index 0x0010, len 2, with payload A, B (pl_tlast on B) -> 3 beats. Header tdata[51:0] = 0x2_0010_03_22_F1F2, tuser[15:0] = 192. Then A, B; tlast only on B; err_len stays 0.
- req len 0 -> single header beat with tlast = 1, tuser[15:0] = 64; pl_tready never asserted.
- req len 3, payload sends one beat with pl_tlast -> beats: header, P, 0, 0 (tlast on last); err_len pulses once.
- req len 1, payload sends 3 beats, tlast on third -> header, first beat with tlast; beats 2–3 accepted and dropped; err_len pulses once; req_ready returns after the third beat.
- pl_tvalid toggling 1,0,0,1 during len 2 -> output bubbles mirror the input gaps; data order and tlast are correct.
- Assert axis_reset during PAYLOAD after one beat -> tvalid = 0 on the next cycle. A fresh len 1 request then yields a correct two-beat packet.
